// File: rtl/tlp_tap_pack.sv
// rtl/tlp_tap_pack.sv - normalises snooped PCIe TLPs to TLP_LEN bytes for the encapsulation FIFO
// Optional statistics counters are built only when TLP_TAP_STATS_EN is defined.
module tlp_tap_pack #(
  parameter int TLP_LEN = 32
) (
  input  logic        clk156,
  input  logic        sys_rst_n,
  input  logic        s_axis_tvalid,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        wr_en,
  output logic [73:0] din,
  input  logic        full,
  input  logic        prog_full,
  output logic [31:0] tlp_cnt,
  output logic [31:0] drop_cnt,
  output logic [31:0] trunc_cnt
);

  localparam int N  = TLP_LEN / 8;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam bit ONE_WORD = (N == 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_PAD     = 3'd2;
  localparam logic [2:0] S_SKIP    = 3'd3;
  localparam logic [2:0] S_DROP    = 3'd4;

  logic [2:0]    st, st_n;
  logic [IW-1:0] idx, idx_n;
  logic          drop_pend, drop_pend_n;
  logic          err_acc, err_acc_n;

  logic          wr_due;
  logic [63:0]   word_data;
  logic          word_last;
  logic          word_user;
  logic [63:0]   beat_data;

  // Zero the bytes of the incoming beat that are not enabled by tkeep.
  always_comb begin
    beat_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (s_axis_tkeep[i]) beat_data[i*8 +: 8] = s_axis_tdata[i*8 +: 8];
    end
  end

  // Next-state logic and the word to be written this cycle.
  always_comb begin
    st_n        = st;
    idx_n       = idx;
    drop_pend_n = drop_pend;
    err_acc_n   = err_acc;
    wr_due      = 1'b0;
    word_data   = '0;
    word_last   = 1'b0;
    word_user   = 1'b0;

    case (st)
      S_IDLE: begin
        idx_n = '0;
        if (s_axis_tvalid) begin
          if (prog_full) begin
            // Not enough room for a whole frame: drop the TLP outright.
            st_n = s_axis_tlast ? S_IDLE : S_DROP;
          end else begin
            wr_due    = 1'b1;
            word_data = beat_data;
            err_acc_n = s_axis_tuser;
            if (ONE_WORD) begin
              word_last = 1'b1;
              word_user = s_axis_tuser;
              err_acc_n = 1'b0;
              st_n      = s_axis_tlast ? S_IDLE : S_SKIP;
            end else begin
              idx_n = IW'(1);
              st_n  = s_axis_tlast ? S_PAD : S_CAPTURE;
            end
          end
        end
      end

      S_CAPTURE: begin
        if (s_axis_tvalid) begin
          wr_due    = 1'b1;
          word_data = beat_data;
          err_acc_n = err_acc | s_axis_tuser;
          if (idx == LAST_IDX) begin
            word_last = 1'b1;
            word_user = err_acc | s_axis_tuser;
            idx_n     = '0;
            st_n      = s_axis_tlast ? S_IDLE : S_SKIP;
          end else begin
            idx_n = idx + IW'(1);
            if (s_axis_tlast) st_n = S_PAD;
          end
        end
      end

      S_PAD: begin
        wr_due = 1'b1;
        // Any beat seen here belongs to a following TLP that cannot be admitted.
        if (s_axis_tvalid) drop_pend_n = ~s_axis_tlast;
        if (idx == LAST_IDX) begin
          word_last   = 1'b1;
          word_user   = err_acc;
          idx_n       = '0;
          st_n        = drop_pend_n ? S_DROP : S_IDLE;
          drop_pend_n = 1'b0;
        end else begin
          idx_n = idx + IW'(1);
        end
      end

      S_SKIP, S_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          st_n  = S_IDLE;
          idx_n = '0;
        end
      end

      default: begin
        st_n        = S_IDLE;
        idx_n       = '0;
        drop_pend_n = 1'b0;
      end
    endcase
  end

  // State registers and the registered FIFO write port.
  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st        <= S_IDLE;
      idx       <= '0;
      drop_pend <= 1'b0;
      err_acc   <= 1'b0;
      wr_en     <= 1'b0;
      din       <= '0;
    end else begin
      st        <= st_n;
      idx       <= idx_n;
      drop_pend <= drop_pend_n;
      err_acc   <= err_acc_n;
      // A write that meets a full FIFO is lost; the sequence still advances.
      wr_en     <= wr_due & ~full;
      if (wr_due) din <= {8'hFF, word_data, word_last, word_user};
    end
  end

`ifdef TLP_TAP_STATS_EN
  logic        inc_tlp, inc_drop, inc_trunc;
  logic [31:0] tlp_q, drop_q, trunc_q;

  assign inc_tlp   = wr_due & ~full & word_last;
  assign inc_drop  = s_axis_tvalid &
                     (((st == S_IDLE) & prog_full) | ((st == S_PAD) & ~drop_pend));
  assign inc_trunc = s_axis_tvalid & ~s_axis_tlast &
                     (((st == S_CAPTURE) & (idx == LAST_IDX)) |
                      (ONE_WORD & (st == S_IDLE) & ~prog_full));

  // Wrapping statistics counters.
  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tlp_q   <= '0;
      drop_q  <= '0;
      trunc_q <= '0;
    end else begin
      if (inc_tlp)   tlp_q   <= tlp_q + 32'd1;
      if (inc_drop)  drop_q  <= drop_q + 32'd1;
      if (inc_trunc) trunc_q <= trunc_q + 32'd1;
    end
  end

  assign tlp_cnt   = tlp_q;
  assign drop_cnt  = drop_q;
  assign trunc_cnt = trunc_q;
`else
  assign tlp_cnt   = '0;
  assign drop_cnt  = '0;
  assign trunc_cnt = '0;
`endif

endmodule

// File: tb/tb_tlp_tap_pack.sv
// tb/tb_tlp_tap_pack.sv - randomized self-checking bench for tlp_tap_pack
module tb_tlp_tap_pack;

  localparam int TLP_LEN = 32;
  localparam int N       = TLP_LEN / 8;
  localparam int T       = 3000;

  logic        clk156 = 1'b0;
  logic        sys_rst_n;
  logic        s_axis_tvalid;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        wr_en;
  logic [73:0] din;
  logic        full;
  logic        prog_full;
  logic [31:0] tlp_cnt;
  logic [31:0] drop_cnt;
  logic [31:0] trunc_cnt;

  always #5 clk156 = ~clk156;

  tlp_tap_pack #(.TLP_LEN(TLP_LEN)) dut (
    .clk156(clk156),
    .sys_rst_n(sys_rst_n),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser),
    .wr_en(wr_en),
    .din(din),
    .full(full),
    .prog_full(prog_full),
    .tlp_cnt(tlp_cnt),
    .drop_cnt(drop_cnt),
    .trunc_cnt(trunc_cnt)
  );

  // Per-cycle stimulus schedule and expected write port.
  bit          a_v    [0:T-1];
  bit          a_last [0:T-1];
  bit          a_user [0:T-1];
  bit          a_pf   [0:T-1];
  bit          a_full [0:T-1];
  logic [63:0] a_data [0:T-1];
  logic [7:0]  a_keep [0:T-1];
  bit          e_wr   [0:T-1];
  logic [73:0] e_din  [0:T-1];

  int cur, free_c;
  int m_tlp, m_drop, m_trunc;
  int checks, failures;

  task automatic check(input string tag, input logic [73:0] got, input logic [73:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mask_bytes(input logic [63:0] d, input logic [7:0] k);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (k[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Schedules one TLP at the cursor and records its expected effect.
  task automatic add_tlp(input int len, input int gap, input bit pf0,
                         input logic [7:0] klast, input bit allf, input int err_beat);
    int          t0;
    logic        err;
    logic [63:0] w;
    bit          lst;
    t0 = cur;
    if (t0 + len + N >= T) return;
    for (int b = 0; b < len; b++) begin
      a_v[t0+b]    = 1'b1;
      a_data[t0+b] = allf ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      a_keep[t0+b] = (b == len - 1) ? klast : 8'hFF;
      a_last[t0+b] = (b == len - 1);
      a_user[t0+b] = (b == err_beat);
    end
    a_pf[t0] = pf0;
    if (t0 < free_c) begin
      // Starts while the previous frame is still padding.
      m_drop++;
      if (t0 + len > free_c) free_c = t0 + len;
    end else if (pf0) begin
      m_drop++;
      free_c = t0 + len;
    end else begin
      err = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (j < len) begin
          w   = mask_bytes(a_data[t0+j], a_keep[t0+j]);
          err = err | a_user[t0+j];
        end else begin
          w = '0;
        end
        lst           = (j == N - 1);
        e_din[t0+j]   = {8'hFF, w, lst, lst & err};
        e_wr[t0+j]    = ~a_full[t0+j];
        if (lst && !a_full[t0+j]) m_tlp++;
      end
      if (len > N) m_trunc++;
      free_c = (len >= N) ? t0 + len : t0 + N;
    end
    cur = t0 + len + gap;
  endtask

  initial begin
    logic [31:0] x_tlp, x_drop, x_trunc;
    checks = 0; failures = 0;
    m_tlp = 0; m_drop = 0; m_trunc = 0;
    for (int c = 0; c < T; c++) begin
      a_v[c] = 0; a_last[c] = 0; a_user[c] = 0;
      a_data[c] = '0; a_keep[c] = '0;
      a_pf[c]   = ($urandom_range(0, 3) == 0);
      a_full[c] = (c >= 200) && ($urandom_range(0, 24) == 0);
      e_wr[c] = 0; e_din[c] = '0;
    end
    free_c = 0;
    cur    = 2;

    // Directed frames first, then random traffic.
    add_tlp(4, 2, 1'b0, 8'hFF, 1'b0, -1);
    add_tlp(3, 2, 1'b0, 8'h0F, 1'b1, -1);
    add_tlp(6, 2, 1'b0, 8'hFF, 1'b0, -1);
    add_tlp(2, 2, 1'b1, 8'hFF, 1'b0, -1);
    add_tlp(4, 2, 1'b0, 8'h3F, 1'b0, -1);
    add_tlp(1, 0, 1'b0, 8'hFF, 1'b0, -1);
    add_tlp(2, 2, 1'b0, 8'hFF, 1'b0, -1);
    add_tlp(3, 2, 1'b0, 8'h01, 1'b0, -1);
    add_tlp(4, 3, 1'b0, 8'hFF, 1'b0, 1);
    while (cur < T - 40) begin
      add_tlp($urandom_range(1, 7),
              ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 4),
              ($urandom_range(0, 5) == 0),
              8'hFF >> $urandom_range(0, 7), 1'b0,
              ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1);
    end

    s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 0; s_axis_tuser = 0; full = 0; prog_full = 0;
    sys_rst_n = 0;
    repeat (2) @(negedge clk156);
    check("reset_wr_en", 74'(wr_en), 74'(0));
    check("reset_din", din, '0);
    check("reset_tlp_cnt", 74'(tlp_cnt), 74'(0));
    check("reset_drop_cnt", 74'(drop_cnt), 74'(0));
    check("reset_trunc_cnt", 74'(trunc_cnt), 74'(0));
    sys_rst_n = 1;

    for (int c = 0; c < T; c++) begin
      s_axis_tvalid = a_v[c];
      s_axis_tdata  = a_data[c];
      s_axis_tkeep  = a_keep[c];
      s_axis_tlast  = a_last[c];
      s_axis_tuser  = a_user[c];
      prog_full     = a_pf[c];
      full          = a_full[c];
      @(posedge clk156);
      @(negedge clk156);
      check($sformatf("wr_en@%0d", c), 74'(wr_en), 74'(e_wr[c]));
      if (e_wr[c]) check($sformatf("din@%0d", c), din, e_din[c]);
    end

`ifdef TLP_TAP_STATS_EN
    x_tlp = 32'(m_tlp); x_drop = 32'(m_drop); x_trunc = 32'(m_trunc);
`else
    x_tlp = '0; x_drop = '0; x_trunc = '0;
`endif
    check("tlp_cnt", 74'(tlp_cnt), 74'(x_tlp));
    check("drop_cnt", 74'(drop_cnt), 74'(x_drop));
    check("trunc_cnt", 74'(trunc_cnt), 74'(x_trunc));

    // Reset asserted in the middle of an admitted TLP.
    s_axis_tvalid = 0; full = 0; prog_full = 0;
    repeat (3) @(negedge clk156);
    s_axis_tvalid = 1; s_axis_tdata = {$urandom, $urandom};
    s_axis_tkeep = 8'hFF; s_axis_tlast = 0; s_axis_tuser = 0;
    @(posedge clk156);
    @(negedge clk156);
    check("pre_reset_wr_en", 74'(wr_en), 74'(1));
    s_axis_tdata = {$urandom, $urandom};
    #1 sys_rst_n = 0;
    #1;
    check("midreset_wr_en", 74'(wr_en), 74'(0));
    check("midreset_din", din, '0);
    check("midreset_tlp_cnt", 74'(tlp_cnt), 74'(0));
    check("midreset_drop_cnt", 74'(drop_cnt), 74'(0));
    check("midreset_trunc_cnt", 74'(trunc_cnt), 74'(0));
    s_axis_tvalid = 0;
    repeat (2) @(negedge clk156);
    sys_rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk156);
      @(negedge clk156);
      check($sformatf("post_reset_wr_en%0d", k), 74'(wr_en), 74'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
